// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Fetch-stage program counter owner. It advances the PC by PC_INC on every
// enabled cycle and redirects it to a branch or jump target. It also
// generates the IF/ID flush and handles hazard stalls, debug-step gating and
// HALT. While the pipeline is frozen (i_enable=0), the first redirect seen is
// held in a pending register and applied on the next enabled cycle.
//
// Configuration macro:
//   DELAY_SLOT_EN - when defined, the instruction after a branch/jump is a
//                   MIPS delay slot, so o_flush_if_id is tied to 0.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-high reset, highest priority
//   i_enable         pipeline advance enable (debug step)
//   i_stall          load-use stall from hazard unit, holds PC
//   i_pc_source      branch taken
//   i_branch_target  branch target address
//   i_jump           unconditional jump / jr decoded
//   i_jump_target    jump target address
//   i_halt           HALT instruction decoded
//   o_pc             current fetch address (registered)
//   o_pc_plus_inc    o_pc + PC_INC (combinational, wraps)
//   o_flush_if_id    kill the instruction entering IF/ID this cycle
//   o_halted         block is in HALT state (registered)
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int NB_PC    = 32,
  parameter int PC_INC   = 4,
  parameter int RESET_PC = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_stall,
  input  logic             i_pc_source,
  input  logic [NB_PC-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic [NB_PC-1:0] i_jump_target,
  input  logic             i_halt,
  output logic [NB_PC-1:0] o_pc,
  output logic [NB_PC-1:0] o_pc_plus_inc,
  output logic             o_flush_if_id,
  output logic             o_halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

`ifdef DELAY_SLOT_EN
  localparam logic FLUSH_EN = 1'b0;
`else
  localparam logic FLUSH_EN = 1'b1;
`endif

  state_t           state_q, state_d;
  logic [NB_PC-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [NB_PC-1:0] pend_target_q, pend_target_d;

  logic             redir;
  logic [NB_PC-1:0] redir_target;
  logic [NB_PC-1:0] pc_plus_inc;
  logic             flush;

  // Branch wins over jump when both are raised in the same cycle.
  assign redir        = i_pc_source | i_jump;
  assign redir_target = i_pc_source ? i_branch_target : i_jump_target;
  assign pc_plus_inc  = pc_q + NB_PC'(PC_INC);

  // Next-state logic. A redirect that was captured while frozen has priority
  // over a live one, and any redirect beats a younger halt or stall because
  // those instructions are on the wrong path.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    flush         = 1'b0;

    case (state_q)
      RUN: begin
        if (i_enable) begin
          if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
            flush        = FLUSH_EN;
          end else if (redir) begin
            pc_d  = redir_target;
            flush = FLUSH_EN;
          end else if (i_halt) begin
            state_d = HALT;
          end else if (!i_stall) begin
            pc_d = pc_plus_inc;
          end
        end else if (redir && !pend_valid_q) begin
          pend_valid_d  = 1'b1;
          pend_target_d = redir_target;
        end
      end
      HALT: begin
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (i_reset) begin
      flush = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= RUN;
      pc_q          <= NB_PC'(RESET_PC);
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc_plus_inc = pc_plus_inc;
  assign o_flush_if_id = flush;
  assign o_halted      = (state_q == HALT);

endmodule
